// File: rtl/i2s_pkg.sv
// Shared I2S frame geometry and slot-to-bit mapping for the transmitter and
// the future master-mode receiver.
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int SLOT_W     = 6;
  localparam int IDX_W      = SLOT_W - 1;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic {
    CHAN_LEFT  = 1'b0,
    CHAN_RIGHT = 1'b1
  } chan_e;

  // Position 0 of each half is the one-bit delay after the word-select edge.
  function automatic logic slot_is_data(input slot_t slot, input int bitsize);
    int pos;
    pos = int'(slot[IDX_W-1:0]);
    return (pos >= 1) && (pos <= bitsize);
  endfunction

  function automatic logic [IDX_W-1:0] slot_bit_index(input slot_t slot, input int bitsize);
    int pos;
    pos = int'(slot[IDX_W-1:0]);
    return IDX_W'(bitsize - pos);
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Stereo sample handshake from the audio pipeline into the I2S transmitter.
interface i2s_tx_if #(
  parameter int BITSIZE = 24
);

  logic [BITSIZE-1:0] left_chan;
  logic [BITSIZE-1:0] right_chan;
  logic               sample_valid;
  logic               sample_ready;

  modport master (
    output left_chan,
    output right_chan,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_chan,
    input  right_chan,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_slot_counter.sv
// Free-running 64-slot I2S frame counter with registered word select.
// lrclk lags slot[5] by one sclk; frame_start is combinational on slot 63; no backpressure.
module i2s_slot_counter
  import i2s_pkg::*;
(
  input  logic  sclk,
  input  logic  rst,
  output slot_t slot,
  output logic  lrclk,
  output logic  frame_start
);

  always_ff @(posedge sclk) begin
    if (rst) begin
      slot  <= '0;
      lrclk <= 1'b0;
    end else begin
      slot  <= slot + 1'b1;
      lrclk <= slot[SLOT_W-1];
    end
  end

  assign frame_start = (slot == slot_t'(FRAME_BITS - 1));

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-pair holding register feeding 64-bit MSB-first frames.
// Pair sent in the frame after acceptance (left MSB 2 sclk after the wrap); ready low while holding is full.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int BITSIZE = 24
) (
  input  logic           sclk,
  input  logic           rst,
  i2s_tx_if.slave        smp,
  output logic           lrclk,
  output logic           sdata,
  output logic           underrun
);

  slot_t                slot;
  logic                 frame_start;
  logic                 full;
  logic                 armed;
  logic                 accept;
  logic [BITSIZE-1:0]   hold_l;
  logic [BITSIZE-1:0]   hold_r;
  logic [SLOT_BITS-1:0] frame_l;
  logic [SLOT_BITS-1:0] frame_r;
  logic [IDX_W-1:0]     bit_idx;
  logic                 sdata_nxt;

  i2s_slot_counter u_slot (
    .sclk        (sclk),
    .rst         (rst),
    .slot        (slot),
    .lrclk       (lrclk),
    .frame_start (frame_start)
  );

  assign smp.sample_ready = ~full;
  assign accept           = smp.sample_valid & ~full;

  // armed stays low until the first wrap so the load out of reset is not an underrun.
  always_ff @(posedge sclk) begin
    if (rst) begin
      full     <= 1'b0;
      armed    <= 1'b0;
      underrun <= 1'b0;
      hold_l   <= '0;
      hold_r   <= '0;
      frame_l  <= '0;
      frame_r  <= '0;
    end else begin
      if (accept) begin
        hold_l <= smp.left_chan;
        hold_r <= smp.right_chan;
      end
      if (frame_start) begin
        full     <= accept;
        armed    <= 1'b1;
        underrun <= armed & ~full;
        frame_l  <= full ? SLOT_BITS'(hold_l) : '0;
        frame_r  <= full ? SLOT_BITS'(hold_r) : '0;
      end else begin
        full     <= full | accept;
        underrun <= 1'b0;
      end
    end
  end

  always_comb begin
    bit_idx   = slot_bit_index(slot, BITSIZE);
    sdata_nxt = 1'b0;
    if (slot_is_data(slot, BITSIZE)) begin
      if (chan_e'(slot[SLOT_W-1]) == CHAN_RIGHT) begin
        sdata_nxt = frame_r[bit_idx];
      end else begin
        sdata_nxt = frame_l[bit_idx];
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      sdata <= 1'b0;
    end else begin
      sdata <= sdata_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: 24-bit and 16-bit instances share sclk and rst,
// serial output is logged per cycle and frames are decoded by slot afterwards.
module tb_i2s_tx;

  logic sclk = 1'b0;
  logic rst;
  logic lr_a, sd_a, ur_a;
  logic lr_b, sd_b, ur_b;

  i2s_tx_if #(.BITSIZE(24)) bus_a ();
  i2s_tx_if #(.BITSIZE(16)) bus_b ();

  i2s_tx #(.BITSIZE(24)) dut_a (
    .sclk     (sclk),
    .rst      (rst),
    .smp      (bus_a.slave),
    .lrclk    (lr_a),
    .sdata    (sd_a),
    .underrun (ur_a)
  );

  i2s_tx #(.BITSIZE(16)) dut_b (
    .sclk     (sclk),
    .rst      (rst),
    .smp      (bus_b.slave),
    .lrclk    (lr_b),
    .sdata    (sd_b),
    .underrun (ur_b)
  );

  always #5 sclk = ~sclk;

  int nvec;
  int nerr;
  int cyc;
  int nacc;
  logic [0:63] got;

  logic hsd_a  [0:1023];
  logic hsd_b  [0:1023];
  logic hacc_a [0:1023];
  logic hacc_b [0:1023];
  logic hur_a  [0:1023];
  logic hrdy_a [0:1023];
  logic hlr_a  [0:1023];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One sclk: accepts are judged on the values presented before the edge.
  task automatic step();
    logic acc_a;
    logic acc_b;
    acc_a = bus_a.sample_valid & bus_a.sample_ready;
    acc_b = bus_b.sample_valid & bus_b.sample_ready;
    @(posedge sclk);
    @(negedge sclk);
    cyc++;
    hsd_a[cyc]  = sd_a;
    hsd_b[cyc]  = sd_b;
    hacc_a[cyc] = acc_a;
    hacc_b[cyc] = acc_b;
    hur_a[cyc]  = ur_a;
    hrdy_a[cyc] = bus_a.sample_ready;
    hlr_a[cyc]  = lr_a;
  endtask

  // Slot s of the frame loaded at wrap cycle 'base' is visible at base+s+1.
  function automatic logic [0:63] frame_of(input int base, input bit use_b);
    logic [0:63] f;
    for (int s = 0; s < 64; s++) begin
      f[s] = use_b ? hsd_b[base + s + 1] : hsd_a[base + s + 1];
    end
    return f;
  endfunction

  function automatic logic exp_lr(input int k);
    if (k == 0) return 1'b0;
    return ((k - 1) % 64) >= 32;
  endfunction

  function automatic logic [23:0] pat_l(input int j);
    return 24'((j + 1) * 'h111111);
  endfunction

  initial begin
    nvec = 0;
    nerr = 0;
    cyc  = 0;
    nacc = 0;
    rst  = 1'b1;
    bus_a.sample_valid = 1'b0;
    bus_a.left_chan    = '0;
    bus_a.right_chan   = '0;
    bus_b.sample_valid = 1'b0;
    bus_b.left_chan    = '0;
    bus_b.right_chan   = '0;

    repeat (3) @(posedge sclk);
    @(negedge sclk);
    rst = 1'b0;
    cyc = 0;
    chk("rst.lrclk", lr_a, 1'b0);
    chk("rst.sdata", sd_a, 1'b0);
    chk("rst.ready", bus_a.sample_ready, 1'b1);
    chk("rst.underrun", ur_a, 1'b0);
    chk("rst.ready_b", bus_b.sample_ready, 1'b1);

    // Idle: word select toggles every 32, no data, underrun only from the 2nd wrap.
    repeat (200) begin
      step();
      chk("idle.lrclk", lr_a, exp_lr(cyc));
      chk("idle.sdata_a", sd_a, 1'b0);
      chk("idle.sdata_b", sd_b, 1'b0);
      chk("idle.underrun_a", ur_a, (cyc == 128) || (cyc == 192));
      chk("idle.underrun_b", ur_b, (cyc == 128) || (cyc == 192));
    end

    // Single pair, plus the 16-bit instance with A5A5 in both slots.
    bus_a.left_chan    = 24'h800001;
    bus_a.right_chan   = 24'h7FFFFE;
    bus_a.sample_valid = 1'b1;
    bus_b.left_chan    = 16'hA5A5;
    bus_b.right_chan   = 16'hA5A5;
    bus_b.sample_valid = 1'b1;
    step();
    chk("single.accept", hacc_a[cyc], 1'b1);
    chk("single.accept_b", hacc_b[cyc], 1'b1);
    chk("single.ready_low", bus_a.sample_ready, 1'b0);
    bus_a.sample_valid = 1'b0;
    bus_a.left_chan    = 24'hFFFFFF;
    bus_a.right_chan   = 24'h000000;
    bus_b.sample_valid = 1'b0;
    bus_b.left_chan    = 16'h0000;
    while (cyc < 320) step();
    got = frame_of(256, 1'b0);
    chk("single.frame24", got, 64'h40000080_3FFFFF00);
    chk("single.l_msb_s1", hsd_a[258], 1'b1);
    chk("single.l_s2", hsd_a[259], 1'b0);
    chk("single.l_lsb_s24", hsd_a[281], 1'b1);
    chk("single.r_s33", hsd_a[290], 1'b0);
    chk("single.r_s34", hsd_a[291], 1'b1);
    chk("single.r_s55", hsd_a[312], 1'b1);
    chk("single.r_s56", hsd_a[313], 1'b0);
    chk("single.lr_before_fall", hlr_a[256], 1'b1);
    chk("single.lr_fall", hlr_a[257], 1'b0);
    chk("single.lr_before_rise", hlr_a[288], 1'b0);
    chk("single.lr_rise", hlr_a[289], 1'b1);
    chk("single.ready_held", hrdy_a[255], 1'b0);
    chk("single.ready_after_load", hrdy_a[256], 1'b1);
    chk("single.no_underrun", hur_a[256], 1'b0);
    chk("single.underrun_next", hur_a[320], 1'b1);
    got = frame_of(256, 1'b1);
    chk("b16.frame", got, 64'h52D28000_52D28000);

    // Valid raised in the slot-63 cycle with holding empty.
    while (cyc < 383) step();
    bus_a.left_chan    = 24'h123456;
    bus_a.right_chan   = 24'hABCDEF;
    bus_a.sample_valid = 1'b1;
    step();
    chk("wrap.accept", hacc_a[cyc], 1'b1);
    chk("wrap.underrun", ur_a, 1'b1);
    chk("wrap.ready_low", bus_a.sample_ready, 1'b0);
    bus_a.sample_valid = 1'b0;
    while (cyc < 512) step();
    got = frame_of(384, 1'b0);
    chk("wrap.cur_frame_zero", got, 64'h0);
    got = frame_of(448, 1'b0);
    chk("wrap.next_frame", got, 64'h091A2B00_55E6F780);
    chk("wrap.no_underrun", hur_a[448], 1'b0);
    chk("wrap.underrun_after", hur_a[512], 1'b1);

    // Back-to-back streaming with valid held high.
    bus_a.left_chan    = pat_l(0);
    bus_a.right_chan   = ~pat_l(0);
    bus_a.sample_valid = 1'b1;
    while (cyc < 896) begin
      step();
      chk("stream.underrun", ur_a, 1'b0);
      if (hacc_a[cyc]) begin
        chk("stream.accept_cycle", cyc, 513 + 64 * nacc);
        nacc++;
        bus_a.left_chan  = pat_l(nacc);
        bus_a.right_chan = ~pat_l(nacc);
      end
    end
    bus_a.sample_valid = 1'b0;
    chk("stream.accept_count", nacc, 6);
    for (int j = 0; j < 5; j++) begin
      got = frame_of(576 + 64 * j, 1'b0);
      chk("stream.frame", got, {1'b0, pat_l(j), 7'b0, 1'b0, ~pat_l(j), 7'b0});
    end

    // Reset at slot 40 while a pair is held.
    bus_a.left_chan    = 24'hFACE01;
    bus_a.right_chan   = 24'h0BEEF0;
    bus_a.sample_valid = 1'b1;
    step();
    chk("rstmid.accept", hacc_a[cyc], 1'b1);
    bus_a.sample_valid = 1'b0;
    while (cyc < 936) step();
    chk("rstmid.held_full", bus_a.sample_ready, 1'b0);
    chk("rstmid.lr_pre", lr_a, 1'b1);
    rst = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    rst = 1'b0;
    cyc = 0;
    chk("rstmid.sdata", sd_a, 1'b0);
    chk("rstmid.lrclk", lr_a, 1'b0);
    chk("rstmid.ready", bus_a.sample_ready, 1'b1);
    chk("rstmid.underrun", ur_a, 1'b0);
    repeat (140) begin
      step();
      chk("rstmid.sdata_after", sd_a, 1'b0);
      chk("rstmid.underrun_after", ur_a, cyc == 128);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
